// File: rtl/bus_protocol_target_if.sv
// rtl/bus_protocol_target_if.sv - dValid/dAck byte bus plus ready/valid drain port
interface bus_protocol_target_if #(
  parameter int DEPTH = 4
) ();
  logic                         dValid;
  logic [7:0]                   data;
  logic                         dAck;
  logic                         out_valid;
  logic [7:0]                   out_data;
  logic                         out_ready;
  logic [$clog2(DEPTH+1)-1:0]   fifo_level;
  logic                         proto_err;
  logic                         overflow;

  modport master (
    output dValid, data, out_ready,
    input  dAck, out_valid, out_data, fifo_level, proto_err, overflow
  );

  modport slave (
    input  dValid, data, out_ready,
    output dAck, out_valid, out_data, fifo_level, proto_err, overflow
  );
endinterface

// File: rtl/bus_protocol_target.sv
// rtl/bus_protocol_target.sv - dValid/dAck bus target with byte FIFO and violation flags
module bus_protocol_target #(
  parameter int ACK_CYCLE = 2,
  parameter int DEPTH     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  bus_protocol_target_if.slave  bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [2:0] RAISE_AT   = 3'(ACK_CYCLE - 1);
  localparam logic [2:0] RAISE_LAST = 3'd3;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACK, S_DONE, S_HOLD} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [2:0]    r_cnt;
  logic [2:0]    w_cnt_inc;
  logic [7:0]    r_ref_data;
  logic          r_mismatch;
  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_dack;
  logic          r_proto_err;
  logic          r_overflow;

  logic          w_full;
  logic          w_out_valid;
  logic          w_pop;
  logic          w_start;
  logic          w_count;
  logic          w_raise;
  logic          w_capture;
  logic          w_data_bad;
  logic          w_push;
  logic          w_drop;
  logic          w_err;

  assign w_full      = (r_level == LW'(DEPTH));
  assign w_out_valid = (r_level != '0);
  assign w_pop       = w_out_valid && bus.out_ready;
  assign w_cnt_inc   = (r_state == S_IDLE) ? 3'd1 : (r_cnt + 3'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (bus.dValid) w_state_next = w_raise ? S_ACK : S_WAIT;
      S_WAIT: begin
        if (!bus.dValid)  w_state_next = S_IDLE;
        else if (w_raise) w_state_next = S_ACK;
      end
      S_ACK:  w_state_next = bus.dValid ? S_DONE : S_IDLE;
      S_DONE: w_state_next = bus.dValid ? S_HOLD : S_IDLE;
      S_HOLD: if (!bus.dValid) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // A full FIFO postpones the raise, but never past c3 so dAck still lands by c4.
  always_comb begin
    w_start    = (r_state == S_IDLE) && bus.dValid;
    w_count    = bus.dValid && ((r_state == S_IDLE) || (r_state == S_WAIT));
    w_raise    = w_count && (w_cnt_inc >= RAISE_AT) &&
                 (!w_full || (w_cnt_inc >= RAISE_LAST));
    w_capture  = (r_state == S_ACK) && bus.dValid;
    w_data_bad = r_mismatch || (bus.data != r_ref_data);
    w_push     = w_capture && !w_data_bad && (!w_full || w_pop);
    w_drop     = w_capture && !w_data_bad && w_full && !w_pop;
    w_err      = ((r_state == S_WAIT) && !bus.dValid) ||
                 ((r_state == S_ACK)  && (!bus.dValid || w_data_bad)) ||
                 ((r_state == S_DONE) && bus.dValid);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dack      <= 1'b0;
      r_proto_err <= 1'b0;
      r_overflow  <= 1'b0;
      r_cnt       <= 3'd0;
      r_ref_data  <= 8'h00;
      r_mismatch  <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
    end else begin
      r_dack      <= w_raise;
      r_proto_err <= w_err;
      r_overflow  <= w_drop;
      if (w_count) r_cnt <= w_cnt_inc;
      if (w_start) begin
        r_ref_data <= bus.data;
        r_mismatch <= 1'b0;
      end else if ((r_state == S_WAIT) && bus.dValid) begin
        r_mismatch <= r_mismatch | (bus.data != r_ref_data);
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage needs no reset: the level register alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.data;
  end

  assign bus.dAck       = r_dack;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_data   = w_out_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign bus.fifo_level = r_level;
  assign bus.proto_err  = r_proto_err;
  assign bus.overflow   = r_overflow;
endmodule
